// File: rtl/range_pkg.sv
// Shared types for the range-finder window sequencer.
package range_pkg;

  localparam int RANGE_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    FINISH,
    LATCH
  } state_t;

endpackage

// File: rtl/range_window_sequencer_if.sv
// Sample stream handshake into the window sequencer.
interface range_window_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             sample_valid;
    logic [WIDTH-1:0] sample_data;
    logic             sample_ready;

    modport master (
        output sample_valid,
        output sample_data,
        input  sample_ready
    );

    modport slave (
        input  sample_valid,
        input  sample_data,
        output sample_ready
    );
endinterface

// File: rtl/range_window_sequencer.sv
// Groups a sporadic sample stream into fixed windows and
// sequences go/finish/latch for the range finder.
module range_window_sequencer
    import range_pkg::*;
#(
    parameter int WIDTH  = RANGE_WIDTH,
    parameter int WINDOW = 8,
    parameter int CNT_W  = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    range_window_sequencer_if.slave smp,
    input  logic                 abort,
    output logic                 rf_go,
    output logic                 rf_finish,
    output logic [WIDTH-1:0]     rf_data,
    input  logic [WIDTH-1:0]     rf_range,
    input  logic                 rf_debug_error,
    output logic [WIDTH-1:0]     result,
    output logic                 result_valid,
    output logic                 aborted,
    output logic [CNT_W-1:0]     window_count,
    output logic                 busy,
    output logic                 err_sticky
);

    localparam int CW = $clog2(WINDOW + 1);
    localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic             discard_q, discard_d;
    logic             go_d, fin_d, rv_d, ab_d;
    logic [WIDTH-1:0] data_d, result_d;
    logic [CNT_W-1:0] wc_d;
    logic             ready, accept;

    assign ready = ((state_q == IDLE) && enable)
                || ((state_q == ACCUM) && !abort);
    assign accept = smp.sample_valid && ready;
    assign smp.sample_ready = ready;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        discard_d = discard_q;
        go_d      = 1'b0;
        fin_d     = 1'b0;
        rv_d      = 1'b0;
        ab_d      = 1'b0;
        data_d    = rf_data;
        result_d  = result;
        wc_d      = window_count;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    go_d    = 1'b1;
                    data_d  = smp.sample_data;
                    count_d = CW'(1);
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                // abort outranks a sample offered in the same cycle
                if (abort) begin
                    fin_d     = 1'b1;
                    discard_d = 1'b1;
                    state_d   = FINISH;
                end else if (accept) begin
                    data_d  = smp.sample_data;
                    count_d = count_q + CW'(1);
                    if (count_q == LAST) begin
                        fin_d   = 1'b1;
                        state_d = FINISH;
                    end
                end
            end
            FINISH: begin
                state_d = LATCH;
            end
            LATCH: begin
                if (!discard_q) begin
                    result_d = rf_range;
                    rv_d     = 1'b1;
                    if (window_count != '1)
                        wc_d = window_count + CNT_W'(1);
                end else begin
                    ab_d = 1'b1;
                end
                discard_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            count_q      <= '0;
            discard_q    <= 1'b0;
            rf_go        <= 1'b0;
            rf_finish    <= 1'b0;
            rf_data      <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            aborted      <= 1'b0;
            window_count <= '0;
            busy         <= 1'b0;
            err_sticky   <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            discard_q    <= discard_d;
            rf_go        <= go_d;
            rf_finish    <= fin_d;
            rf_data      <= data_d;
            result       <= result_d;
            result_valid <= rv_d;
            aborted      <= ab_d;
            window_count <= wc_d;
            busy         <= (state_d != IDLE);
            err_sticky   <= err_sticky | rf_debug_error;
        end
    end

endmodule

// File: tb/tb_range_window_sequencer.sv
// Directed bench for range_window_sequencer with a
// behavioural max-minus-min range finder alongside.
module tb_range_window_sequencer;

    localparam int W   = 16;
    localparam int WIN = 4;
    localparam int CW  = 3;

    logic          clock = 1'b0;
    logic          reset, enable, abort, rf_debug_error;
    logic          rf_go, rf_finish, result_valid, aborted;
    logic          busy, err_sticky;
    logic [W-1:0]  rf_data, rf_range, result;
    logic [CW-1:0] window_count;

    int checks = 0;
    int errors = 0;
    int go_seen, fin_seen;

    range_window_sequencer_if #(.WIDTH(W)) sif ();

    range_window_sequencer #(
        .WIDTH (W),
        .WINDOW(WIN),
        .CNT_W (CW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .smp           (sif.slave),
        .abort         (abort),
        .rf_go         (rf_go),
        .rf_finish     (rf_finish),
        .rf_data       (rf_data),
        .rf_range      (rf_range),
        .rf_debug_error(rf_debug_error),
        .result        (result),
        .result_valid  (result_valid),
        .aborted       (aborted),
        .window_count  (window_count),
        .busy          (busy),
        .err_sticky    (err_sticky)
    );

    always #5 clock = ~clock;

    // range finder: tracks min/max of data_in from go to finish
    logic [W-1:0] mn, mx;
    logic         act;
    always @(posedge clock) begin
        if (reset) begin
            mn <= '0; mx <= '0; act <= 1'b0;
        end else if (rf_go) begin
            mn <= rf_data; mx <= rf_data; act <= 1'b1;
        end else if (act) begin
            if (rf_data < mn) mn <= rf_data;
            if (rf_data > mx) mx <= rf_data;
            if (rf_finish) act <= 1'b0;
        end
    end
    assign rf_range = mx - mn;

    task automatic tick;
        @(posedge clock);
        #1;
        go_seen  += int'(rf_go);
        fin_seen += int'(rf_finish);
    endtask

    task automatic send(input logic [W-1:0] d, input int gap);
        sif.sample_valid = 1'b1;
        sif.sample_data  = d;
        tick();
        sif.sample_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            tick();
            checks++;
            if (rf_data !== d) begin
                errors++;
                $display("FAIL gap_hold got %0d want %0d", rf_data, d);
            end
        end
    endtask

    task automatic wait_result(input logic [W-1:0] er,
                               input logic [CW-1:0] ewc);
        int n = 0;
        while (!result_valid && n < 8) begin
            tick();
            n++;
        end
        checks++;
        if (result_valid !== 1'b1) begin
            errors++;
            $display("FAIL result_timeout got %b want 1", result_valid);
        end
        checks++;
        if (result !== er || window_count !== ewc) begin
            errors++;
            $display("FAIL result got %0d/%0d want %0d/%0d",
                     result, window_count, er, ewc);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; enable = 1'b0; abort = 1'b0;
        rf_debug_error = 1'b0;
        sif.sample_valid = 1'b0; sif.sample_data = '0;
        tick(); tick();
        reset = 1'b0;
        checks++;
        if ({rf_go, rf_finish, result_valid, aborted, busy,
             err_sticky, sif.sample_ready} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 0",
                     {rf_go, rf_finish, result_valid, aborted,
                      busy, err_sticky, sif.sample_ready});
        end
        checks++;
        if (result !== '0 || rf_data !== '0 || window_count !== '0) begin
            errors++;
            $display("FAIL reset_regs got %0d/%0d/%0d want 0/0/0",
                     result, rf_data, window_count);
        end
    endtask

    task automatic test_idle_gating;
        go_seen = 0;
        sif.sample_valid = 1'b1; sif.sample_data = 16'd77;
        abort = 1'b1;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || go_seen != 0 || aborted !== 1'b0) begin
            errors++;
            $display("FAIL idle_gating got busy=%b go=%0d ab=%b want 0",
                     busy, go_seen, aborted);
        end
        sif.sample_valid = 1'b0; abort = 1'b0;
    endtask

    task automatic test_back_to_back;
        go_seen = 0; fin_seen = 0;
        enable = 1'b1;
        sif.sample_valid = 1'b1; sif.sample_data = 16'd10;
        tick();
        checks++;
        if (rf_go !== 1'b1 || rf_data !== 16'd10 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_go got %b/%0d want 1/10", rf_go, rf_data);
        end
        sif.sample_data = 16'd50; tick();
        checks++;
        if (rf_go !== 1'b0 || rf_data !== 16'd50) begin
            errors++;
            $display("FAIL b2b_second got %b/%0d want 0/50", rf_go, rf_data);
        end
        sif.sample_data = 16'd3;  tick();
        sif.sample_data = 16'd20; tick();
        sif.sample_valid = 1'b0;
        checks++;
        if (rf_finish !== 1'b1) begin
            errors++;
            $display("FAIL b2b_finish got %b want 1", rf_finish);
        end
        tick();
        checks++;
        if (rf_finish !== 1'b0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_latch got %b/%b want 0/0",
                     rf_finish, result_valid);
        end
        tick();
        checks++;
        if (result_valid !== 1'b1 || result !== 16'd47
            || window_count !== 3'd1) begin
            errors++;
            $display("FAIL b2b_result got %b/%0d/%0d want 1/47/1",
                     result_valid, result, window_count);
        end
        tick();
        checks++;
        if (result_valid !== 1'b0 || go_seen != 1 || fin_seen != 1) begin
            errors++;
            $display("FAIL b2b_pulses got %b/%0d/%0d want 0/1/1",
                     result_valid, go_seen, fin_seen);
        end
    endtask

    task automatic test_gaps;
        go_seen = 0; fin_seen = 0;
        send(16'd10, 1);
        send(16'd50, 0);
        send(16'd3, 3);
        send(16'd20, 0);
        wait_result(16'd47, 3'd2);
        checks++;
        if (go_seen != 1 || fin_seen != 1) begin
            errors++;
            $display("FAIL gaps_pulses got %0d/%0d want 1/1",
                     go_seen, fin_seen);
        end
    endtask

    task automatic test_abort;
        send(16'd100, 0);
        send(16'd200, 0);
        sif.sample_valid = 1'b1; sif.sample_data = 16'd999;
        abort = 1'b1;
        #1;
        checks++;
        if (sif.sample_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_ready got %b want 0", sif.sample_ready);
        end
        tick();
        checks++;
        if (rf_finish !== 1'b1 || rf_data !== 16'd200) begin
            errors++;
            $display("FAIL abort_finish got %b/%0d want 1/200",
                     rf_finish, rf_data);
        end
        abort = 1'b0; sif.sample_valid = 1'b0;
        tick(); tick();
        checks++;
        if (aborted !== 1'b1 || result_valid !== 1'b0
            || result !== 16'd47 || window_count !== 3'd2) begin
            errors++;
            $display("FAIL abort_pulse got %b/%b/%0d/%0d want 1/0/47/2",
                     aborted, result_valid, result, window_count);
        end
        tick();
        checks++;
        if (aborted !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_after got %b/%b want 0/0", aborted, busy);
        end
    endtask

    task automatic test_hold_through;
        send(16'd10, 0);
        send(16'd50, 0);
        send(16'd3, 0);
        sif.sample_valid = 1'b1; sif.sample_data = 16'd20;
        tick();
        sif.sample_data = 16'd7;
        checks++;
        if (sif.sample_ready !== 1'b0 || rf_finish !== 1'b1) begin
            errors++;
            $display("FAIL hold_finish got %b/%b want 0/1",
                     sif.sample_ready, rf_finish);
        end
        tick();
        checks++;
        if (sif.sample_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL hold_latch got %b/%b want 0/1",
                     sif.sample_ready, busy);
        end
        tick();
        checks++;
        if (result_valid !== 1'b1 || result !== 16'd47
            || window_count !== 3'd3 || sif.sample_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_idle got %b/%0d/%0d/%b want 1/47/3/1",
                     result_valid, result, window_count, sif.sample_ready);
        end
        tick();
        checks++;
        if (rf_go !== 1'b1 || rf_data !== 16'd7) begin
            errors++;
            $display("FAIL hold_go got %b/%0d want 1/7", rf_go, rf_data);
        end
        sif.sample_data = 16'd9;
        tick();
        sif.sample_valid = 1'b0;
    endtask

    task automatic test_reset_mid;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || result !== '0 || window_count !== '0
            || rf_data !== '0 || rf_go !== 1'b0 || rf_finish !== 1'b0
            || result_valid !== 1'b0 || aborted !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got busy=%b res=%0d wc=%0d data=%0d",
                     busy, result, window_count, rf_data);
        end
        for (int i = 0; i < WIN; i++) send(16'd5, 0);
        wait_result(16'd0, 3'd1);
    endtask

    task automatic test_err_sticky;
        rf_debug_error = 1'b1;
        tick();
        rf_debug_error = 1'b0;
        tick();
        checks++;
        if (err_sticky !== 1'b1) begin
            errors++;
            $display("FAIL err_set got %b want 1", err_sticky);
        end
        send(16'd1, 0);
        enable = 1'b0;
        send(16'd2, 1);
        send(16'd3, 0);
        send(16'd9, 0);
        wait_result(16'd8, 3'd2);
        enable = 1'b1;
        checks++;
        if (err_sticky !== 1'b1) begin
            errors++;
            $display("FAIL err_hold got %b want 1", err_sticky);
        end
    endtask

    task automatic test_saturate;
        for (int i = 0; i < 6; i++) begin
            for (int s = 0; s < WIN; s++) send(W'(s), 0);
            wait_result(16'd3, (3 + i > 7) ? 3'd7 : CW'(3 + i));
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (err_sticky !== 1'b0 || window_count !== '0) begin
            errors++;
            $display("FAIL sat_reset got %b/%0d want 0/0",
                     err_sticky, window_count);
        end
    endtask

    initial begin
        test_reset();
        test_idle_gating();
        test_back_to_back();
        test_gaps();
        test_abort();
        test_hold_through();
        test_reset_mid();
        test_err_sticky();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
